// File: rtl/fft_reorder.sv
`default_nettype none
// ============================================================================
// fft_reorder : ping-pong bit-reversal buffer that turns the last FFT stage's
//               bit-reversed stream into natural-order bins with a ready/valid
//               output handshake.
// Revision    : 1.0
// ============================================================================
module fft_reorder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              iclk,
  input  logic              rst,
  input  logic              ien,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata,
  input  logic              oready,
  output logic              ovalid,
  output logic [DATA_W-1:0] odata,
  output logic [ADDR_W-1:0] oindex,
  output logic              olast,
  output logic              odrop
);

  localparam int N = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  logic [DATA_W-1:0] bank0 [N];
  logic [DATA_W-1:0] bank1 [N];

  state_t            state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wsel_q, wsel_d;
  logic              rsel_q, rsel_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic              ovalid_q, ovalid_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [ADDR_W-1:0] oindex_q, oindex_d;
  logic              olast_q, olast_d;

  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] rd_data;
  logic              load;
  logic              rd_done;
  logic [1:0]        clr_vec;
  logic [1:0]        full_eff;
  logic              wr_en;
  logic              drop;

  always_comb begin
    waddr = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      waddr[i] = iaddr[ADDR_W-1-i];
    end
  end

  assign rd_data = rsel_q ? bank1[rcnt_q] : bank0[rcnt_q];
  assign load    = (state_q == READ) && (!ovalid_q || oready);
  assign rd_done = load && (rcnt_q == LAST_ADDR);

  // A bank freed by the read side on this edge is already writable on this edge.
  always_comb begin
    clr_vec = 2'b00;
    if (rd_done) clr_vec[rsel_q] = 1'b1;
  end

  assign full_eff = full_q & ~clr_vec;
  assign wr_en    = ien && !full_eff[wsel_q];
  assign drop     = ien && full_eff[wsel_q];

  always_comb begin
    full_d   = full_eff;
    wsel_d   = wsel_q;
    state_d  = state_q;
    rsel_d   = rsel_q;
    rcnt_d   = rcnt_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    oindex_d = oindex_q;
    olast_d  = olast_q;

    if (wr_en && (iaddr == LAST_ADDR)) begin
      full_d[wsel_q] = 1'b1;
      wsel_d         = ~wsel_q;
    end

    case (state_q)
      IDLE: begin
        rcnt_d = '0;
        if (full_q[rsel_q]) state_d = READ;
      end
      READ: begin
        if (load) begin
          odata_d  = rd_data;
          oindex_d = rcnt_q;
          olast_d  = (rcnt_q == LAST_ADDR);
          ovalid_d = 1'b1;
          rcnt_d   = rcnt_q + ADDR_W'(1);
          if (rcnt_q == LAST_ADDR) begin
            rsel_d  = ~rsel_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!load && oready) ovalid_d = 1'b0;
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q  <= IDLE;
      full_q   <= 2'b00;
      wsel_q   <= 1'b0;
      rsel_q   <= 1'b0;
      rcnt_q   <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      oindex_q <= '0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wsel_q   <= wsel_d;
      rsel_q   <= rsel_d;
      rcnt_q   <= rcnt_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      oindex_q <= oindex_d;
      olast_q  <= olast_d;
    end
  end

  always_ff @(posedge iclk) begin
    if (!rst && wr_en) begin
      if (wsel_q) bank1[waddr] <= idata;
      else        bank0[waddr] <= idata;
    end
  end

  assign ovalid = ovalid_q;
  assign odata  = odata_q;
  assign oindex = oindex_q;
  assign olast  = olast_q;
  assign odrop  = drop && !rst;

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder.sv
`default_nettype none
// ============================================================================
// tb_fft_reorder : directed bench for fft_reorder at N=8 (ADDR_W=3).
// Revision       : 1.0
// ============================================================================
module tb_fft_reorder;

  logic        iclk = 1'b0;
  logic        rst;
  logic        ien;
  logic [2:0]  iaddr;
  logic [31:0] idata;
  logic        oready;
  logic        ovalid;
  logic [31:0] odata;
  logic [2:0]  oindex;
  logic        olast;
  logic        odrop;

  always #5 iclk = ~iclk;

  fft_reorder #(.ADDR_W(3), .DATA_W(32)) dut (
    .iclk   (iclk),
    .rst    (rst),
    .ien    (ien),
    .iaddr  (iaddr),
    .idata  (idata),
    .oready (oready),
    .ovalid (ovalid),
    .odata  (odata),
    .oindex (oindex),
    .olast  (olast),
    .odrop  (odrop)
  );

  typedef struct {
    int          at;
    logic [2:0]  idx;
    logic [31:0] data;
    logic        last;
  } rec_t;

  rec_t q[$];
  int   ecnt = 0;
  int   drops = 0;
  int   hold_err = 0;
  int   checks = 0;
  int   failures = 0;
  int   rv[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic        pv = 1'b0, pr = 1'b0, prst = 1'b1, pl = 1'b0;
  logic [31:0] pd = '0;
  logic [2:0]  pi = '0;

  always @(posedge iclk) ecnt++;

  // Handshake capture, drop counting and hold checking, all mid-cycle.
  always @(negedge iclk) begin
    if (ovalid && oready) q.push_back('{ecnt, oindex, odata, olast});
    if (odrop) drops++;
    if (pv && !pr && !prst) begin
      if (!(ovalid && odata == pd && oindex == pi && olast == pl)) hold_err++;
    end
    pv = ovalid; pr = oready; pd = odata; pi = oindex; pl = olast; prst = rst;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int pos, input logic [2:0] idx,
                         input logic [31:0] data);
    logic [63:0] obs;
    obs = '1;
    if (pos < q.size()) obs = {28'd0, q[pos].last, q[pos].idx, q[pos].data};
    chk($sformatf("%s[%0d]", tag, pos), obs, {28'd0, (idx == 3'd7), idx, data});
  endtask

  task automatic cyc(input logic e, input logic [2:0] a, input logic [31:0] d, input logic r);
    ien = e; iaddr = a; idata = d; oready = r;
    @(posedge iclk); #1;
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) cyc(1'b0, 3'd0, 32'd0, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e7;
    int k;
    rst = 1'b1; ien = 1'b0; iaddr = '0; idata = '0; oready = 1'b1;
    repeat (2) @(posedge iclk);
    #1;
    chk("reset_ovalid", 64'(ovalid), 64'd0);
    chk("reset_outs", {26'd0, olast, odrop, oindex, odata}, 64'd0);
    rst = 1'b0;

    // Single frame, data = iaddr: natural order yields bit-reversed values.
    q.delete(); drops = 0;
    for (int a = 0; a < 8; a++) cyc(1'b1, 3'(a), 32'(a), 1'b1);
    e7 = ecnt;
    idle(14, 1'b1);
    chk("f1_count", 64'(q.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk_rec("f1_rec", i, 3'(i), 32'(rv[i]));
    if (q.size() == 8) begin
      chk("f1_latency", 64'(q[0].at - e7), 64'd2);
      chk("f1_contig", 64'(q[7].at - q[0].at), 64'd7);
    end else chk("f1_count_guard", 64'(q.size()), 64'd8);

    // Three frames streamed back to back.
    q.delete(); drops = 0;
    for (int f = 0; f < 3; f++)
      for (int a = 0; a < 8; a++) cyc(1'b1, 3'(a), 32'(16 * f + a), 1'b1);
    idle(20, 1'b1);
    chk("b2b_drops", 64'(drops), 64'd0);
    chk("b2b_count", 64'(q.size()), 64'd24);
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 8; i++) chk_rec("b2b_rec", 8 * f + i, 3'(i), 32'(16 * f + rv[i]));
    if (q.size() == 24) begin
      chk("b2b_gap1", 64'(q[8].at - q[7].at), 64'd2);
      chk("b2b_gap2", 64'(q[16].at - q[15].at), 64'd2);
      chk("b2b_span", 64'(q[7].at - q[0].at), 64'd7);
    end else chk("b2b_count_guard", 64'(q.size()), 64'd24);

    // Backpressure pattern 1,0,0,1 repeating.
    q.delete(); drops = 0; hold_err = 0;
    for (int t = 0; t < 40; t++) begin
      if (t < 8) cyc(1'b1, 3'(t), 32'h100 + 32'(t), (t % 4 == 0) || (t % 4 == 3));
      else       cyc(1'b0, 3'd0, 32'd0, (t % 4 == 0) || (t % 4 == 3));
    end
    chk("bp_count", 64'(q.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk_rec("bp_rec", i, 3'(i), 32'h100 + 32'(rv[i]));
    chk("bp_hold", 64'(hold_err), 64'd0);
    chk("bp_drops", 64'(drops), 64'd0);

    // Stalled output: third frame must be dropped entirely.
    q.delete(); drops = 0; hold_err = 0;
    for (int f = 0; f < 3; f++)
      for (int a = 0; a < 8; a++) cyc(1'b1, 3'(a), 32'h200 + 32'(16 * f + a), 1'b0);
    chk("stall_drops", 64'(drops), 64'd8);
    chk("stall_none_out", 64'(q.size()), 64'd0);
    chk("stall_head", {60'd0, ovalid, oindex}, {60'd0, 1'b1, 3'd0});
    idle(30, 1'b1);
    chk("stall_count", 64'(q.size()), 64'd16);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++)
        chk_rec("stall_rec", 8 * f + i, 3'(i), 32'h200 + 32'(16 * f + rv[i]));
    chk("stall_hold", 64'(hold_err), 64'd0);

    // Reset during readout, with another one-sample frame already queued.
    for (int a = 0; a < 8; a++) cyc(1'b1, 3'(a), 32'h300 + 32'(a), 1'b1);
    cyc(1'b1, 3'd7, 32'h3ff, 1'b1);
    idle(4, 1'b1);
    chk("rst_pre", {60'd0, ovalid, oindex}, {60'd0, 1'b1, 3'd3});
    rst = 1'b1;
    cyc(1'b0, 3'd0, 32'd0, 1'b1);
    rst = 1'b0;
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_outs", {28'd0, olast, oindex, odata}, 64'd0);

    // Frame completes into bank 0 on the same edge bank 0's read finishes.
    q.delete(); drops = 0;
    for (int a = 0; a < 8; a++) cyc(1'b1, 3'(a), 32'h400 + 32'(a), 1'b1);
    k = ecnt;
    for (int a = 0; a < 8; a++) cyc(1'b1, 3'(a), 32'h500 + 32'(a), 1'b1);
    cyc(1'b1, 3'd7, 32'h600, 1'b1);
    chk("coll_edge", 64'(ecnt - k), 64'd9);
    idle(35, 1'b1);
    chk("coll_drops", 64'(drops), 64'd0);
    chk("coll_count", 64'(q.size()), 64'd24);
    for (int i = 0; i < 8; i++) chk_rec("coll_a", i, 3'(i), 32'h400 + 32'(rv[i]));
    for (int i = 0; i < 8; i++) chk_rec("coll_b", 8 + i, 3'(i), 32'h500 + 32'(rv[i]));
    for (int i = 0; i < 8; i++)
      chk_rec("coll_c", 16 + i, 3'(i), (i == 7) ? 32'h600 : 32'h400 + 32'(rv[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
